nbit_register_file_clr: RTL and testbench

Parametrised two-read/one-write register file for the multicycle CPU datapath. It generalises data width and depth and adds an optional hardwired zero register and optional write-to-read bypass. A hardware clear sequencer zeroes every entry after reset and on request, replacing the simulation-only `initial` clear. It sits between the instruction-decode register selects and the ALU operand muxes.

---
 rtl/nbit_register_file_clr.sv | 94 +++++++++
 tb/tb_nbit_register_file_clr.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nbit_register_file_clr.sv
// Two-read/one-write register file with a hardware clear sequencer that zeroes
// every entry after reset and on request.
module nbit_register_file_clr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_sel_1,
  input  logic [ADDR_WIDTH-1:0] read_sel_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  // state    | meaning
  // ST_CLEAR | zeroing entry clr_cnt each edge, user writes dropped
  // ST_IDLE  | normal read/write, clr_req accepted
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_cnt  <= '0;
      clr_busy <= 1'b1;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (state == ST_CLEAR) begin
        if (RegWrite) wr_drop <= 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
          clr_cnt  <= '0;
        end else begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
      end else if (clr_req) begin
        state    <= ST_CLEAR;
        clr_busy <= 1'b1;
        clr_cnt  <= '0;
      end
    end
  end

  // Array has no reset; the sequencer is what guarantees known contents.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (RegWrite && !(ZERO_REG && (write_address == '0))) begin
      mem[write_address] <= write_data;
    end
  end

  always_comb begin
    read_data_1 = mem[read_sel_1];
    if (clr_busy) begin
      read_data_1 = '0;
    end else if (ZERO_REG && (read_sel_1 == '0)) begin
      read_data_1 = '0;
    end else if (BYPASS && RegWrite && (read_sel_1 == write_address)) begin
      read_data_1 = write_data;
    end
  end

  always_comb begin
    read_data_2 = mem[read_sel_2];
    if (clr_busy) begin
      read_data_2 = '0;
    end else if (ZERO_REG && (read_sel_2 == '0)) begin
      read_data_2 = '0;
    end else if (BYPASS && RegWrite && (read_sel_2 == write_address)) begin
      read_data_2 = write_data;
    end
  end

endmodule

// File: tb/tb_nbit_register_file_clr.sv
// Bench for nbit_register_file_clr: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_nbit_register_file_clr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  read_sel_1, read_sel_2;
  logic [31:0] read_data_1, read_data_2;
  logic        clr_req;
  logic        clr_busy, clr_done, wr_drop;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model: m_idx = next entry to zero, -1 when not clearing
  int          m_idx = 0;
  bit          m_done = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_mem [32];

  nbit_register_file_clr #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
    .write_address(write_address), .write_data(write_data),
    .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] sel);
    if (!rst_n || m_idx >= 0) return 32'h0;
    if (sel == 5'd0) return 32'h0;
    if (RegWrite && sel == write_address) return write_data;
    return m_mem[sel];
  endfunction

  always @(negedge rst_n) begin
    m_idx  = 0;
    m_done = 1'b0;
    m_drop = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idx  = 0;
      m_done = 1'b0;
      m_drop = 1'b0;
    end else if (m_idx >= 0) begin
      m_mem[m_idx] = 32'h0;
      if (RegWrite) m_drop = 1'b1;
      m_done = (m_idx == 31);
      m_idx  = (m_idx == 31) ? -1 : m_idx + 1;
    end else begin
      m_done = 1'b0;
      if (RegWrite && write_address != 5'd0) m_mem[write_address] = write_data;
      if (clr_req) m_idx = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("model_busy", {31'd0, clr_busy}, {31'd0, (!rst_n || m_idx >= 0)});
      check("model_done", {31'd0, clr_done}, {31'd0, (rst_n && m_done)});
      check("model_drop", {31'd0, wr_drop}, {31'd0, (rst_n && m_drop)});
      check("model_rd1", read_data_1, ref_read(read_sel_1));
      check("model_rd2", read_data_2, ref_read(read_sel_2));
    end
  end

  // Counts consecutive sampled cycles with clr_busy high, starting at the current one.
  task automatic run_len(output int n);
    n = 0;
    while (clr_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    rst_n = 1'b0; RegWrite = 1'b0; write_address = '0; write_data = '0;
    read_sel_1 = '0; read_sel_2 = '0; clr_req = 1'b0;
    chk_en = 1'b1;

    // reset state and initial clear
    @(negedge clk); read_sel_1 = 5'd9; #1;
    check("rst_busy", {31'd0, clr_busy}, 32'd1);
    check("rst_done", {31'd0, clr_done}, 32'd0);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    check("rst_rd1", read_data_1, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    run_len(n);
    check("init_busy_len", n, 32'd32);
    check("init_done", {31'd0, clr_done}, 32'd1);
    @(negedge clk); #1;
    check("init_done_pulse", {31'd0, clr_done}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); read_sel_1 = 5'(i); read_sel_2 = 5'(31 - i); #1;
      check("init_zero_rd1", read_data_1, 32'h0);
      check("init_zero_rd2", read_data_2, 32'h0);
    end

    // write with bypass, then registered read
    @(negedge clk);
    RegWrite = 1'b1; write_address = 5'd7; write_data = 32'hDEADBEEF;
    read_sel_1 = 5'd7; read_sel_2 = 5'd7; #1;
    check("bypass_rd1", read_data_1, 32'hDEADBEEF);
    @(negedge clk); RegWrite = 1'b0; write_data = 32'h0; #1;
    check("wr7_rd1", read_data_1, 32'hDEADBEEF);
    check("wr7_rd2", read_data_2, 32'hDEADBEEF);

    // hardwired zero entry
    @(negedge clk);
    RegWrite = 1'b1; write_address = 5'd0; write_data = 32'h12345678; read_sel_1 = 5'd0; #1;
    check("zero_bypass", read_data_1, 32'h0);
    @(negedge clk); RegWrite = 1'b0; #1;
    check("zero_stored", read_data_1, 32'h0);

    // fill, request clear, write during clear
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); RegWrite = 1'b1; write_address = 5'(i); write_data = 32'(i);
    end
    @(negedge clk); RegWrite = 1'b0; clr_req = 1'b1; read_sel_1 = 5'd5; read_sel_2 = 5'd31; #1;
    check("fill_rd5", read_data_1, 32'd5);
    check("fill_rd31", read_data_2, 32'd31);
    @(negedge clk); clr_req = 1'b0; RegWrite = 1'b1; write_address = 5'd3; write_data = 32'hFF;
    read_sel_1 = 5'd3; #1;
    check("clr_busy_on", {31'd0, clr_busy}, 32'd1);
    check("clr_rd_zero", read_data_1, 32'h0);
    @(negedge clk); RegWrite = 1'b0; #1;
    check("wr_drop_set", {31'd0, wr_drop}, 32'd1);
    run_len(n);
    check("req_busy_len", n, 32'd31);
    check("req_done", {31'd0, clr_done}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); read_sel_1 = 5'(i); read_sel_2 = 5'(i); #1;
      check("after_clr_rd1", read_data_1, 32'h0);
    end
    check("wr_drop_sticky", {31'd0, wr_drop}, 32'd1);

    // reset in the middle of a requested clear
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    check("midrst_busy", {31'd0, clr_busy}, 32'd1);
    check("midrst_drop", {31'd0, wr_drop}, 32'd0);
    check("midrst_done", {31'd0, clr_done}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    run_len(n);
    check("midrst_busy_len", n, 32'd32);
    check("midrst_done_after", {31'd0, clr_done}, 32'd1);

    // back-to-back clears with clr_req held
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); #1;
    run_len(n);
    check("b2b_len1", n, 32'd32);
    check("b2b_gap_done", {31'd0, clr_done}, 32'd1);
    @(negedge clk); #1;
    check("b2b_restart", {31'd0, clr_busy}, 32'd1);
    run_len(n);
    check("b2b_len2", n, 32'd32);
    clr_req = 1'b0;
    @(negedge clk); #1;
    run_len(n);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n         = ($urandom_range(0, 599) != 0);
      RegWrite      = 1'($urandom_range(0, 1));
      write_address = 5'($urandom_range(0, 31));
      write_data    = $urandom;
      read_sel_1    = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom_range(0, 31));
      read_sel_2    = ($urandom_range(0, 3) == 0) ? write_address : 5'($urandom_range(0, 31));
      clr_req       = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); rst_n = 1'b1; RegWrite = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    #4;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
